// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALU operations and the datapath multiplexer selects.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECUTER = 4'd6,
        ST_EXECUTEI = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_JAL      = 4'd9,
        ST_BRANCH   = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Coarse ALU request from the FSM; ALUOP_FUNCT defers to funct3/funct7.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction fields and status flowing from the datapath to the controller,
// and the control strobes/selects flowing back.
interface multicycle_controller_if;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;

    // Datapath side owns the instruction fields and the zero flag.
    modport master (
        output op, funct3, funct7b5, zero,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
        input  result_src, alu_src_a, alu_src_b, imm_src, alu_control
    );

    modport slave (
        input  op, funct3, funct7b5, zero,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
        output result_src, alu_src_a, alu_src_b, imm_src, alu_control
    );

endinterface

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALU request plus funct fields onto an ALU operation.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       op5_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_control_o
);

    // Only R-type (op[5]=1) may select sub; addi ignores funct7b5.
    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_SUB:   alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default:     alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main FSM of the multicycle RV32I core with Moore-decoded control outputs.
// Reset forces FETCH-style selects with every write strobe suppressed.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.slave  bus
);

    state_t     state_q;
    state_t     state_d;
    state_t     out_state;
    logic [1:0] alu_op;
    logic [2:0] alu_control;
    logic       branch_taken;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;

    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:    state_d = ST_DECODE;
            ST_DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = ST_MEMADR;
                    OP_RTYPE:          state_d = ST_EXECUTER;
                    OP_ITYPE:          state_d = ST_EXECUTEI;
                    OP_JAL:            state_d = ST_JAL;
                    OP_BRANCH:         state_d = ST_BRANCH;
                    default:           state_d = ST_FETCH;
                endcase
            end
            ST_MEMADR:   state_d = (bus.op == OP_STORE) ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD:  state_d = ST_MEMWB;
            ST_EXECUTER: state_d = ST_ALUWB;
            ST_EXECUTEI: state_d = ST_ALUWB;
            ST_JAL:      state_d = ST_ALUWB;
            default:     state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    // During reset the selects already look like FETCH; strobes are masked below.
    assign out_state = reset ? ST_FETCH : state_q;

    assign branch_taken = (bus.funct3 == 3'b000) ? bus.zero :
                          (bus.funct3 == 3'b001) ? ~bus.zero : 1'b0;

    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        case (out_state)
            ST_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
            end
            ST_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            ST_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEMREAD:  adr_src = 1'b1;
            ST_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            ST_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            ST_EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_FUNCT;
            end
            ST_EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            ST_ALUWB:    reg_write = 1'b1;
            ST_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_SUB;
                pc_write  = branch_taken;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (bus.op)
            OP_LOAD, OP_ITYPE: imm_src = IMM_I;
            OP_STORE:          imm_src = IMM_S;
            OP_BRANCH:         imm_src = IMM_B;
            OP_JAL:            imm_src = IMM_J;
            default:           imm_src = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct3_i      (bus.funct3),
        .op5_i         (bus.op[5]),
        .funct7b5_i    (bus.funct7b5),
        .alu_control_o (alu_control)
    );

    assign bus.pc_write    = pc_write  & ~reset;
    assign bus.mem_write   = mem_write & ~reset;
    assign bus.ir_write    = ir_write  & ~reset;
    assign bus.reg_write   = reg_write & ~reset;
    assign bus.adr_src     = adr_src;
    assign bus.result_src  = result_src;
    assign bus.alu_src_a   = alu_src_a;
    assign bus.alu_src_b   = alu_src_b;
    assign bus.imm_src     = imm_src;
    assign bus.alu_control = alu_control;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle RV32I core. It sequences instruction fetch, decode, execute, memory and write-back over several cycles. It drives the register file write enable, the ALU and multiplexer selects, the IR/PC write strobes and the memory write strobe. It sits beside the datapath, reads opcode/funct fields from the instruction register and the ALU `zero` flag, and exposes Moore-decoded control.

## Interface
- No parameters.
- `clk`  in  1  system clock; state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `op`  in  7  instr[6:0].
- `funct3`  in  3  instr[14:12].
- `funct7b5`  in  1  instr[30].
- `zero`  in  1  ALU result == 0.
- `pc_write`  out  1  PC load enable.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALU result register.
- `mem_write`  out  1  data memory write enable.
- `ir_write`  out  1  IR and old-PC load enable.
- `reg_write`  out  1  register file `we`.
- `result_src`  out  2  result select: 00 = ALUOut, 01 = data, 10 = ALU result.
- `alu_src_a`  out  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1.
- `alu_src_b`  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = const 4.
- `imm_src`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- `alu_control`  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BRANCH.
- FETCH: `ir_write`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, add, `result_src`=10, PC update. Goes to DECODE.
- DECODE: `alu_src_a`=01, `alu_src_b`=01, add (branch target). Next state by `op`:
  - 0000011 / 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1101111 → JAL
  - 1100011 → BRANCH
  - any other opcode → FETCH, with no write strobes (treated as NOP).
- MEMADR: `alu_src_a`=10, `alu_src_b`=01, add. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: `adr_src`=1, `result_src`=00. Goes to MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1. Goes to FETCH.
- MEMWRITE: `adr_src`=1, `result_src`=00, `mem_write`=1. Goes to FETCH.
- EXECUTER: `alu_src_a`=10, `alu_src_b`=00, funct decode. Goes to ALUWB.
- EXECUTEI: `alu_src_a`=10, `alu_src_b`=01, funct decode. Goes to ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1. Goes to FETCH.
- JAL: `alu_src_a`=01, `alu_src_b`=10, add, `result_src`=00, PC update. Goes to ALUWB (rd = PC+4).
- BRANCH: `alu_src_a`=10, `alu_src_b`=00, sub, `result_src`=00. `pc_write` = `zero` for funct3 000 (beq) and `!zero` for funct3 001 (bne); other funct3 never taken. Goes to FETCH.
- `imm_src` is decoded from `op` in every state: I for load/OP-IMM, S for store, B for branch, J for jal, 00 otherwise.
- Funct decode:
  - funct3 000: sub if `op[5]&funct7b5`, else add (addi always add)
  - 010: slt; 110: or; 111: and; any other funct3: add.
- Unused selects in each state are 00. Write strobes are 0 unless listed above.

## Timing
- All outputs are combinational functions of the state register plus `op`/`funct3`/`funct7b5`/`zero`. There are no output registers.
- Cycles per instruction: lw 5, sw 4, R 4, I 4, jal 4, beq/bne 3, unknown opcode 2.
- `reg_write` is high for exactly one cycle per writing instruction. The register file samples on the falling edge inside that cycle.
- Reset:
  - `reset`=1 at a rising edge → state = FETCH, regardless of current state (mid-instruction aborts, nothing completes).
  - While `reset`=1, `pc_write`, `ir_write`, `reg_write` and `mem_write` are forced 0. Other outputs show FETCH values.
  - First fetch occurs in the cycle after `reset` deasserts.
- `zero` is sampled only in BRANCH and is don't-care elsewhere.

## Structure
- Package `riscv_ctrl_pkg`: state encoding (4-bit localparams), opcode constants, `alu_control` encodings, select encodings for `result_src`/`alu_src_a`/`alu_src_b`/`imm_src`.
- Sub-module `alu_decoder`: combinational; inputs alu_op[1:0] (00 add, 01 sub, 10 funct), `funct3`, `op[5]`, `funct7b5`; output `alu_control`.
- Main FSM plus output decode live in `multicycle_controller`.

## Test plan
- Reset held 3 cycles, then released with `op`=0110011 → all write strobes 0 during reset; first post-reset cycle `ir_write`=1, `pc_write`=1.
- `op`=0000011 → FETCH, DECODE, MEMADR, MEMREAD, MEMWB; `reg_write`=1 only in cycle 5 with `result_src`=01; `adr_src`=1 in cycle 4.
- `op`=0100011 → `mem_write`=1 only in cycle 4, `imm_src`=01, `reg_write` never 1.
- `op`=0110011, `funct3`=000, `funct7b5`=1 → `alu_control`=001 in EXECUTER. `op`=0010011 with same fields → 000.
- `op`=1100011, `funct3`=001: with `zero`=0 → `pc_write`=1 in cycle 3; with `zero`=1 → 0. Back to FETCH in cycle 4.
- `op`=1111111 → DECODE then FETCH with no strobes. Separately, `reset` asserted during MEMREAD → next state FETCH and MEMWB never entered.
